crop_video_config_slave: RTL and testbench
==========================================

# crop_video_config_slave

Register-side responder for the crop video configuration interface. It accepts single-beat write and read transactions from the configuration initiator into shadow crop registers. It validates a commit request against the frame limits. It transfers the committed window to the active crop outputs only at a frame boundary, so the crop datapath never sees a window change mid-frame.

## Interface
Parameters:
- DATA_W, 16, width of the configuration data and crop coordinates.
- MAX_W, 1920, frame width in pixels; upper bound for x_start + width.
- MAX_H, 1080, frame height in lines; upper bound for y_start + height.

Ports:
- clock  in  1  single clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cfg_valid  in  1  initiator request valid.
- cfg_ready  out  1  responder can accept a request.
- cfg_write  in  1  1 = write, 0 = read.
- cfg_addr  in  3  register address.
- cfg_wdata  in  DATA_W  write data.
- cfg_rvalid  out  1  read data valid.
- cfg_rready  in  1  initiator accepts read data.
- cfg_rdata  out  DATA_W  read data.
- frame_start  in  1  one-cycle pulse at the start of each frame.
- crop_x_start, crop_y_start, crop_width, crop_height  out  DATA_W each  active crop window.
- cfg_applied  out  1  one-cycle pulse when the active window is updated.
- cfg_error  out  1  sticky flag: the last commit was illegal.

## Operation
- Register map:
  - 0 X_START (RW), 1 Y_START (RW), 2 WIDTH (RW), 3 HEIGHT (RW).
  - 4 CTRL: write bit0 = 1 requests a commit; reads return 0.
  - 5 STATUS (RO): bit0 pending, bit1 error, others 0.
  - Writes to 5–7 are ignored; reads of 6–7 return 0.
- Reads of addresses 0–3 return the shadow registers, not the active ones.
- FSM states: S_IDLE and S_RD_RESP.
  - S_IDLE: cfg_ready = 1. On cfg_valid with cfg_write = 1, perform the write and stay in S_IDLE. On cfg_valid with cfg_write = 0, latch the read data into cfg_rdata and go to S_RD_RESP.
  - S_RD_RESP: cfg_ready = 0 and cfg_rvalid = 1. On cfg_rready, return to S_IDLE.
- Commit (CTRL write with bit0 = 1). All checks use DATA_W+1-bit sums. The commit is legal when all of these hold:
  - WIDTH ≠ 0 and HEIGHT ≠ 0;
  - X_START + WIDTH ≤ MAX_W;
  - Y_START + HEIGHT ≤ MAX_H.
- Legal commit:
  - copy the shadow registers into the staged set;
  - set pending;
  - clear error.
- Illegal commit:
  - set error;
  - leave the staged set and pending unchanged.
- A commit while already pending overwrites the staged set (latest legal commit wins).
- Shadow writes after a commit do not affect the staged set.
- On frame_start with pending = 1:
  - copy the staged set into the active outputs;
  - clear pending;
  - pulse cfg_applied.
- frame_start with pending = 0 has no effect.
- Commit and frame_start in the same cycle:
  - if pending was already set, the old staged set is applied, then the new commit is staged and pending stays 1;
  - if pending was 0, the new commit is staged, pending is set, and it applies at the next frame_start.
- Reset values:
  - shadow, staged and active sets: x = 0, y = 0, width = MAX_W, height = MAX_H;
  - pending = 0, error = 0;
  - state = S_IDLE, cfg_ready = 1, cfg_rvalid = 0, cfg_rdata = 0, cfg_applied = 0.
- Reset asserted mid-read drops cfg_rvalid in the next cycle, with no handshake completion.

## Timing
- Write: accepted in cycle N; the register holds the new value from N+1.
- A read issued at N+1 returns the value written at N.
- Read: accepted at N; cfg_rvalid and cfg_rdata are valid from N+1 and held stable until the cfg_rready cycle. cfg_ready is low during that time.
- Back-to-back reads: at most one read per two cycles when cfg_rready is held high.
- frame_start sampled at N: active outputs change at N+1, and cfg_applied is high in N+1 only.
- STATUS reflects a commit or an apply in the cycle after it occurs.

## Structure
- Shared package crop_video_config_pkg_hdl holds:
  - the address constants (ADDR_X_START … ADDR_STATUS);
  - the STATUS bit positions;
  - a crop_window_t struct (x_start, y_start, width, height) used for the shadow, staged and active sets.
- Sub-module crop_video_config_check: a combinational legality checker that takes crop_window_t plus MAX_W/MAX_H and outputs legal. It is reusable by the datapath's assertions.

## Test plan
- Reset, then read all addresses → 0, 0, 1920, 1080, 0, STATUS = 0, 0, 0. Active outputs are 0/0/1920/1080.
- Write X = 100, Y = 50, W = 640, H = 480, commit, then pulse frame_start → STATUS.pending = 1 before the pulse; outputs become 100/50/640/480 one cycle after frame_start; cfg_applied pulses once.
- Write X = 1500, W = 640, commit → cfg_error = 1, pending = 0, active window unchanged. Then write W = 420, commit → error = 0, pending = 1.
- Commit window A, write X = 200 without recommitting, frame_start → window A is applied, while the shadow X reads 200.
- Commit in the same cycle as a frame_start while window A is pending → A is applied, the new window is pending and applies at the next frame_start.
- Read with cfg_rready held low for 5 cycles → cfg_rvalid and cfg_rdata stay stable and cfg_ready = 0. Assert reset on cycle 3 → cfg_rvalid = 0 and cfg_ready = 1 on the next cycle.

Source files
------------

// File: rtl/crop_video_config_pkg_hdl.sv
// Shared definitions for the crop video configuration slave:
// register addresses, STATUS/CTRL bit positions, the crop window struct
// used for the shadow/staged/active sets, and the FSM state type.
package crop_video_config_pkg_hdl;

  // Field width of crop_window_t; the slave's DATA_W must match it.
  localparam int CROP_DATA_W = 16;

  localparam logic [2:0] ADDR_X_START = 3'd0;
  localparam logic [2:0] ADDR_Y_START = 3'd1;
  localparam logic [2:0] ADDR_WIDTH   = 3'd2;
  localparam logic [2:0] ADDR_HEIGHT  = 3'd3;
  localparam logic [2:0] ADDR_CTRL    = 3'd4;
  localparam logic [2:0] ADDR_STATUS  = 3'd5;

  localparam int CTRL_COMMIT    = 0;
  localparam int STATUS_PENDING = 0;
  localparam int STATUS_ERROR   = 1;

  typedef struct packed {
    logic [CROP_DATA_W-1:0] x_start;
    logic [CROP_DATA_W-1:0] y_start;
    logic [CROP_DATA_W-1:0] width;
    logic [CROP_DATA_W-1:0] height;
  } crop_window_t;

  typedef enum logic {S_IDLE, S_RD_RESP} cfg_state_t;

  // Full-frame window used as the reset value of every set.
  function automatic crop_window_t full_frame(input int max_w, input int max_h);
    crop_window_t w;
    w.x_start = '0;
    w.y_start = '0;
    w.width   = CROP_DATA_W'(max_w);
    w.height  = CROP_DATA_W'(max_h);
    return w;
  endfunction

endpackage

// File: rtl/crop_video_config_check.sv
// Combinational legality check of a crop window against the frame size.
// Ports:
//   win   in  crop window to check
//   legal out 1 when width/height are non-zero and the window fits the frame
// Sums are one bit wider than the fields so they cannot wrap.
module crop_video_config_check
  import crop_video_config_pkg_hdl::*;
#(
  parameter int MAX_W = 1920,
  parameter int MAX_H = 1080
) (
  input  crop_window_t win,
  output logic         legal
);

  localparam logic [CROP_DATA_W:0] MAX_W_L = (CROP_DATA_W+1)'(MAX_W);
  localparam logic [CROP_DATA_W:0] MAX_H_L = (CROP_DATA_W+1)'(MAX_H);

  logic [CROP_DATA_W:0] x_end;
  logic [CROP_DATA_W:0] y_end;

  assign x_end = {1'b0, win.x_start} + {1'b0, win.width};
  assign y_end = {1'b0, win.y_start} + {1'b0, win.height};

  assign legal = (win.width != '0) && (win.height != '0) &&
                 (x_end <= MAX_W_L) && (y_end <= MAX_H_L);

endmodule

// File: rtl/crop_video_config_slave.sv
// Register-side responder for the crop configuration interface.
// Writes land in shadow registers; a CTRL commit validates the shadow set
// and stages it; the staged set reaches the active outputs only on a
// frame_start, so the crop datapath never sees a mid-frame change.
// Ports:
//   clock, reset              clock, synchronous active-high reset
//   cfg_valid/ready/write     request handshake and direction
//   cfg_addr, cfg_wdata       register address and write data
//   cfg_rvalid/rready/rdata   read response handshake and data
//   frame_start               one-cycle frame boundary pulse
//   crop_*                    active crop window
//   cfg_applied               one-cycle pulse when the active window updates
//   cfg_error                 sticky: the last commit was illegal
module crop_video_config_slave
  import crop_video_config_pkg_hdl::*;
#(
  parameter int DATA_W = 16,
  parameter int MAX_W  = 1920,
  parameter int MAX_H  = 1080
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic              cfg_write,
  input  logic [2:0]        cfg_addr,
  input  logic [DATA_W-1:0] cfg_wdata,
  output logic              cfg_rvalid,
  input  logic              cfg_rready,
  output logic [DATA_W-1:0] cfg_rdata,
  input  logic              frame_start,
  output logic [DATA_W-1:0] crop_x_start,
  output logic [DATA_W-1:0] crop_y_start,
  output logic [DATA_W-1:0] crop_width,
  output logic [DATA_W-1:0] crop_height,
  output logic              cfg_applied,
  output logic              cfg_error
);

  localparam crop_window_t RST_WIN = full_frame(MAX_W, MAX_H);

  cfg_state_t   state, state_nxt;
  crop_window_t shadow, staged, active;
  logic         pending;
  logic         legal;
  logic         wr_en, rd_en, commit, apply;
  logic [DATA_W-1:0] rd_mux;

  crop_video_config_check #(.MAX_W(MAX_W), .MAX_H(MAX_H)) u_check (
    .win   (shadow),
    .legal (legal)
  );

  // FSM: state register
  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // FSM: next state and handshake outputs
  always_comb begin
    state_nxt  = state;
    cfg_ready  = 1'b0;
    cfg_rvalid = 1'b0;
    case (state)
      S_IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid && !cfg_write) state_nxt = S_RD_RESP;
      end
      S_RD_RESP: begin
        cfg_rvalid = 1'b1;
        if (cfg_rready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign wr_en  = cfg_ready && cfg_valid && cfg_write;
  assign rd_en  = cfg_ready && cfg_valid && !cfg_write;
  assign commit = wr_en && (cfg_addr == ADDR_CTRL) && cfg_wdata[CTRL_COMMIT];
  // Apply uses the pre-edge staged set, so a same-cycle commit only
  // replaces what gets applied at the following frame_start.
  assign apply  = frame_start && pending;

  always_comb begin
    rd_mux = '0;
    case (cfg_addr)
      ADDR_X_START: rd_mux = shadow.x_start;
      ADDR_Y_START: rd_mux = shadow.y_start;
      ADDR_WIDTH:   rd_mux = shadow.width;
      ADDR_HEIGHT:  rd_mux = shadow.height;
      ADDR_STATUS: begin
        rd_mux[STATUS_PENDING] = pending;
        rd_mux[STATUS_ERROR]   = cfg_error;
      end
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      shadow      <= RST_WIN;
      staged      <= RST_WIN;
      active      <= RST_WIN;
      pending     <= 1'b0;
      cfg_error   <= 1'b0;
      cfg_applied <= 1'b0;
      cfg_rdata   <= '0;
    end else begin
      cfg_applied <= apply;
      if (rd_en) cfg_rdata <= rd_mux;

      if (wr_en) begin
        case (cfg_addr)
          ADDR_X_START: shadow.x_start <= cfg_wdata;
          ADDR_Y_START: shadow.y_start <= cfg_wdata;
          ADDR_WIDTH:   shadow.width   <= cfg_wdata;
          ADDR_HEIGHT:  shadow.height  <= cfg_wdata;
          default: ;
        endcase
      end

      if (apply) begin
        active  <= staged;
        pending <= 1'b0;
      end

      // Later assignments win: a legal commit keeps pending set even
      // when an apply happens in the same cycle.
      if (commit) begin
        if (legal) begin
          staged    <= shadow;
          pending   <= 1'b1;
          cfg_error <= 1'b0;
        end else begin
          cfg_error <= 1'b1;
        end
      end
    end
  end

  assign crop_x_start = active.x_start;
  assign crop_y_start = active.y_start;
  assign crop_width   = active.width;
  assign crop_height  = active.height;

endmodule

// File: tb/tb_crop_video_config_slave.sv
// Self-checking bench for crop_video_config_slave: directed scenarios
// followed by random traffic, checked against an array-based model.
module tb_crop_video_config_slave;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_valid = 1'b0, cfg_write = 1'b0, cfg_rready = 1'b0, frame_start = 1'b0;
  logic [2:0]  cfg_addr = '0;
  logic [15:0] cfg_wdata = '0;
  logic        cfg_ready, cfg_rvalid, cfg_applied, cfg_error;
  logic [15:0] cfg_rdata, crop_x_start, crop_y_start, crop_width, crop_height;

  crop_video_config_slave #(.DATA_W(16), .MAX_W(1920), .MAX_H(1080)) dut (
    .clock(clock), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_write(cfg_write),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_rvalid(cfg_rvalid), .cfg_rready(cfg_rready), .cfg_rdata(cfg_rdata),
    .frame_start(frame_start),
    .crop_x_start(crop_x_start), .crop_y_start(crop_y_start),
    .crop_width(crop_width), .crop_height(crop_height),
    .cfg_applied(cfg_applied), .cfg_error(cfg_error)
  );

  always #5 clock = ~clock;

  // model: index 0..3 = x, y, width, height
  int m_sh[4], m_st[4], m_ac[4];
  bit m_pend, m_err;
  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_sh = '{0, 0, 1920, 1080};
    m_st = '{0, 0, 1920, 1080};
    m_ac = '{0, 0, 1920, 1080};
    m_pend = 0;
    m_err  = 0;
  endtask

  function automatic int model_rd(input bit [2:0] a);
    if (a < 3'd4) return m_sh[a[1:0]];
    if (a == 3'd5) return int'({m_err, m_pend});
    return 0;
  endfunction

  task automatic check_outs(input bit app);
    chk("x_start", crop_x_start, m_ac[0]);
    chk("y_start", crop_y_start, m_ac[1]);
    chk("width",   crop_width,   m_ac[2]);
    chk("height",  crop_height,  m_ac[3]);
    chk("applied", cfg_applied,  app);
    chk("error",   cfg_error,    m_err);
  endtask

  // One clock with the given request; model advances by the same rules.
  task automatic step(input bit v, input bit w, input bit [2:0] a, input int d, input bit fs);
    bit app, legal;
    cfg_valid = v; cfg_write = w; cfg_addr = a; cfg_wdata = d[15:0]; frame_start = fs;
    @(posedge clock); #1;
    cfg_valid = 0; cfg_write = 0; frame_start = 0;
    app = fs && m_pend;
    if (app) begin
      m_ac = m_st;
      m_pend = 0;
    end
    if (v && w && a == 3'd4 && d[0]) begin
      legal = (m_sh[2] != 0) && (m_sh[3] != 0) &&
              (m_sh[0] + m_sh[2] <= 1920) && (m_sh[1] + m_sh[3] <= 1080);
      if (legal) begin
        m_st = m_sh;
        m_pend = 1;
        m_err = 0;
      end else m_err = 1;
    end
    if (v && w && a < 3'd4) m_sh[a[1:0]] = d & 32'hFFFF;
    check_outs(app);
  endtask

  task automatic wr(input bit [2:0] a, input int d, input bit fs = 0);
    step(1, 1, a, d, fs);
  endtask

  task automatic rd(input bit [2:0] a, input int hold, input bit rnd_fs = 0);
    int exp;
    exp = model_rd(a);
    step(1, 0, a, 0, 0);
    chk("rvalid", cfg_rvalid, 1);
    chk("ready_busy", cfg_ready, 0);
    chk("rdata", cfg_rdata, exp);
    for (int i = 0; i < hold; i++) begin
      step(0, 0, 0, 0, rnd_fs && ($urandom_range(0, 2) == 0));
      chk("rvalid_hold", cfg_rvalid, 1);
      chk("rdata_hold", cfg_rdata, exp);
      chk("ready_hold", cfg_ready, 0);
    end
    cfg_rready = 1;
    step(0, 0, 0, 0, 0);
    cfg_rready = 0;
    chk("ready_back", cfg_ready, 1);
    chk("rvalid_drop", cfg_rvalid, 0);
  endtask

  task automatic wr_win(input int x, input int y, input int w, input int h);
    wr(0, x); wr(1, y); wr(2, w); wr(3, h);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clock);
    #1 reset = 0;
    check_outs(0);
    chk("rst_ready", cfg_ready, 1);
    chk("rst_rvalid", cfg_rvalid, 0);
    chk("rst_rdata", cfg_rdata, 0);
    for (int a = 0; a < 8; a++) rd(3'(a), 0);

    // basic commit and apply
    wr_win(100, 50, 640, 480);
    wr(4, 1);
    rd(5, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    rd(5, 0);

    // illegal commit, then corrected one (1500 + 420 = 1920 is the limit)
    wr(0, 1500); wr(2, 640);
    wr(4, 1);
    rd(5, 0);
    wr(2, 420);
    wr(4, 1);
    rd(5, 0);
    step(0, 0, 0, 0, 1);
    // zero size and height overflow are illegal; frame_start without pending is a no-op
    wr_win(0, 0, 0, 10); wr(4, 1);
    wr_win(0, 1, 10, 1080); wr(4, 1);
    step(0, 0, 0, 0, 1);
    wr_win(0, 0, 1920, 1080); wr(4, 1);

    // shadow write after commit does not affect the staged set
    wr_win(10, 20, 100, 100);
    wr(4, 1);
    wr(0, 200);
    step(0, 0, 0, 0, 1);
    rd(0, 0);

    // commit in the same cycle as an apply of a pending window
    wr_win(30, 40, 300, 200);
    wr(4, 1);
    wr_win(60, 70, 800, 600);
    wr(4, 1, 1);
    rd(5, 0);
    step(0, 0, 0, 0, 1);
    // commit with frame_start while nothing is pending
    wr_win(5, 6, 7, 8);
    wr(4, 1, 1);
    step(0, 0, 0, 0, 1);

    // read held for 5 cycles
    rd(2, 5);

    // reset in the middle of a read response
    begin
      int exp;
      exp = model_rd(3);
      step(1, 0, 3, 0, 0);
      step(0, 0, 0, 0, 0);
      chk("rd_mid_rdata", cfg_rdata, exp);
      chk("rd_mid_rvalid", cfg_rvalid, 1);
      reset = 1;
      @(posedge clock); #1;
      reset = 0;
      model_reset();
      chk("rst_rd_rvalid", cfg_rvalid, 0);
      chk("rst_rd_ready", cfg_ready, 1);
      check_outs(0);
    end

    // random traffic
    for (int it = 0; it < 600; it++) begin
      int r;
      bit fs;
      bit [2:0] a;
      r  = $urandom_range(0, 9);
      fs = ($urandom_range(0, 3) == 0);
      a  = 3'($urandom_range(0, 7));
      if (r < 5) wr(a, (a < 3'd4) ? $urandom_range(0, 1300) : $urandom, fs);
      else if (r < 7) wr(4, $urandom_range(0, 3), fs);
      else if (r == 7) rd(a, $urandom_range(0, 2), 1);
      else step(0, 0, 0, 0, fs);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
